// File: rtl/ddr3_burst_reader.sv
// DDR3 EMIF burst reader: turns a byte-addressed read request into burst commands
// and delivers the returned words with byte masks through a show-ahead buffer.
module ddr3_burst_reader #(
    parameter int DATA_W     = 256,
    parameter int ADDR_W     = 22,
    parameter int BURST_MAX  = 16,
    parameter int FIFO_DEPTH = 128
) (
    input  logic                                     ddr3_emif_clk,
    input  logic                                     ddr3_emif_rst,
    input  logic                                     ddr3_emif_ready,
    output logic                                     ddr3_emif_read,
    output logic [ADDR_W-1:0]                        ddr3_emif_addr,
    output logic [$clog2(BURST_MAX):0]               ddr3_emif_burst_count,
    input  logic [DATA_W-1:0]                        ddr3_emif_read_data,
    input  logic                                     ddr3_emif_rddata_valid,
    input  logic                                     rd_start,
    input  logic [ADDR_W+$clog2(DATA_W/8)-1:0]       rd_byte_addr,
    input  logic [31:0]                              rd_byte_cnt,
    output logic                                     rd_busy,
    output logic                                     rd_done,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [DATA_W-1:0]                        out_data,
    output logic [DATA_W/8-1:0]                      out_mask,
    output logic                                     out_last
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int BC_W  = $clog2(BURST_MAX) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CR_W  = CNT_W + 1;
    localparam int FW    = DATA_W + BYTES + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CALC  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]              state;
    logic [ADDR_W+OFF_W-1:0] lat_addr;
    logic [31:0]             lat_cnt;
    logic [32:0]             total_words;
    logic [32:0]             words_left;
    logic [ADDR_W-1:0]       cur_addr;
    logic                    cmd_read;
    logic [ADDR_W-1:0]       cmd_addr;
    logic [BC_W-1:0]         cmd_bc;
    logic [CNT_W-1:0]        outstanding;
    logic [32:0]             beat_idx;

    logic [FW-1:0]           mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        fifo_cnt;
    logic [FW-1:0]           head;

    logic [OFF_W-1:0]        off;
    logic [OFF_W-1:0]        end_off;
    logic [32:0]             end_sum;
    logic [32:0]             tw_calc;
    logic [BC_W-1:0]         burst_sel;
    logic [CR_W-1:0]         credit;
    logic                    can_issue;
    logic                    acc;
    logic                    beat;
    logic                    pop;
    logic                    beat_last;
    logic [BYTES-1:0]        first_mask;
    logic [BYTES-1:0]        last_mask;
    logic [BYTES-1:0]        beat_mask;

    always_comb begin
        off        = lat_addr[OFF_W-1:0];
        end_sum    = {1'b0, lat_cnt} + 33'(off);
        end_off    = end_sum[OFF_W-1:0];
        tw_calc    = (end_sum + 33'(BYTES - 1)) >> OFF_W;
        burst_sel  = (words_left >= 33'(BURST_MAX)) ? BC_W'(BURST_MAX) : BC_W'(words_left);
        // count + outstanding never exceeds depth, so this difference cannot go negative
        credit     = CR_W'(FIFO_DEPTH) - {1'b0, fifo_cnt} - {1'b0, outstanding};
        can_issue  = credit >= CR_W'(burst_sel);
        acc        = cmd_read & ddr3_emif_ready;
        beat       = ddr3_emif_rddata_valid & (outstanding != '0);
        pop        = out_valid & out_ready;
        beat_last  = (beat_idx == total_words - 33'd1);
        first_mask = {BYTES{1'b1}} << off;
        last_mask  = (end_off == '0) ? {BYTES{1'b1}} : ~({BYTES{1'b1}} << end_off);
        beat_mask  = ((beat_idx == '0) ? first_mask : {BYTES{1'b1}}) &
                     (beat_last ? last_mask : {BYTES{1'b1}});
    end

    always_ff @(posedge ddr3_emif_clk or posedge ddr3_emif_rst) begin
        if (ddr3_emif_rst) begin
            state       <= S_IDLE;
            lat_addr    <= '0;
            lat_cnt     <= '0;
            total_words <= '0;
            words_left  <= '0;
            cur_addr    <= '0;
            cmd_read    <= 1'b0;
            cmd_addr    <= '0;
            cmd_bc      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rd_start) begin
                        lat_addr <= rd_byte_addr;
                        lat_cnt  <= rd_byte_cnt;
                        state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    total_words <= tw_calc;
                    words_left  <= tw_calc;
                    cur_addr    <= lat_addr[ADDR_W+OFF_W-1:OFF_W];
                    state       <= (lat_cnt == '0) ? S_DONE : S_ISSUE;
                end
                S_ISSUE: begin
                    if (acc) begin
                        cmd_read   <= 1'b0;
                        cur_addr   <= cur_addr + ADDR_W'(cmd_bc);
                        words_left <= words_left - 33'(cmd_bc);
                    end else if (!cmd_read) begin
                        if (words_left == '0) begin
                            state <= S_DRAIN;
                        end else if (can_issue) begin
                            cmd_read <= 1'b1;
                            cmd_addr <= cur_addr;
                            cmd_bc   <= burst_sel;
                        end
                    end
                end
                S_DRAIN: begin
                    if (outstanding == '0) state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge ddr3_emif_clk or posedge ddr3_emif_rst) begin
        if (ddr3_emif_rst) begin
            outstanding <= '0;
            beat_idx    <= '0;
        end else begin
            outstanding <= outstanding + (acc ? CNT_W'(cmd_bc) : '0) - (beat ? CNT_W'(1) : '0);
            if (state == S_CALC)
                beat_idx <= '0;
            else if (beat)
                beat_idx <= beat_idx + 33'd1;
        end
    end

    always_ff @(posedge ddr3_emif_clk or posedge ddr3_emif_rst) begin
        if (ddr3_emif_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (beat) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (beat && !pop)
                fifo_cnt <= fifo_cnt + CNT_W'(1);
            else if (pop && !beat)
                fifo_cnt <= fifo_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge ddr3_emif_clk) begin
        if (beat) mem[wr_ptr] <= {beat_last, beat_mask, ddr3_emif_read_data};
    end

    assign head                  = mem[rd_ptr];
    assign out_valid             = (fifo_cnt != '0);
    assign out_data              = head[DATA_W-1:0];
    assign out_mask              = head[DATA_W +: BYTES];
    assign out_last              = out_valid & head[FW-1];
    assign ddr3_emif_read        = cmd_read;
    assign ddr3_emif_addr        = cmd_addr;
    assign ddr3_emif_burst_count = cmd_bc;
    assign rd_busy               = (state != S_IDLE);
    assign rd_done               = (state == S_DONE);

endmodule

// File: doc/ddr3_burst_reader.md
DDR3_BURST_READER -- requirements
Module: ddr3_burst_reader

Interface
REQ-001 Parameters (name, default, meaning):
  DATA_W, 256, EMIF data width in bits; power of two, at least 64; BYTES = DATA_W/8, OFF_W = log2(BYTES).
  ADDR_W, 22, EMIF word-address width.
  BURST_MAX, 16, maximum beats per read command; power of two; burst-count width BC_W = log2(BURST_MAX)+1.
  FIFO_DEPTH, 128, depth of the internal output buffer in words; power of two, at least 2*BURST_MAX.
REQ-002 Ports (name, direction, width, meaning):
  ddr3_emif_clk  in  1  single clock.
  ddr3_emif_rst  in  1  asynchronous, active-high reset.
  ddr3_emif_ready  in  1  EMIF accepts command; low means wait.
  ddr3_emif_read  out  1  read command valid.
  ddr3_emif_addr  out  ADDR_W  burst start word address.
  ddr3_emif_burst_count  out  BC_W  beats in this command.
  ddr3_emif_read_data  in  DATA_W  returned beat.
  ddr3_emif_rddata_valid  in  1  returned beat valid.
  rd_start  in  1  one-cycle request pulse.
  rd_byte_addr  in  ADDR_W+OFF_W  start byte address.
  rd_byte_cnt  in  32  bytes to read.
  rd_busy  out  1  high from accepted start until done.
  rd_done  out  1  one-cycle pulse when the request completes.
  out_valid  out  1  output word valid.
  out_ready  in  1  consumer accepts the word.
  out_data  out  DATA_W  output word.
  out_mask  out  BYTES  byte valid; bit i qualifies out_data[8i+7:8i].
  out_last  out  1  final word of the request.

Function
REQ-003 States: IDLE, CALC, ISSUE, DRAIN, DONE. rd_start in IDLE latches inputs and moves to CALC; rd_start outside IDLE is ignored.
REQ-004 CALC, one cycle:
  - off = rd_byte_addr[OFF_W-1:0]; word_addr = rd_byte_addr upper bits.
  - total_words = ceil((off + rd_byte_cnt) / BYTES), computed without overflow in 33 bits.
  - rd_byte_cnt == 0: go to DONE with no EMIF traffic.
  - otherwise go to ISSUE.
REQ-005 The first ddr3_emif_read assertion occurs no earlier than 2 cycles after the rd_start cycle.
REQ-006 ISSUE burst size:
  - burst = min(BURST_MAX, words_left).
  - A command is presented only when FIFO free entries minus outstanding beats is at least burst (credit rule; the FIFO never overflows).
REQ-007 Command handshake:
  - ddr3_emif_read, addr and burst_count are held stable while ddr3_emif_ready is low.
  - A command is accepted on a cycle with read and ready both high.
  - On acceptance: the address advances by burst, words_left decreases by burst, and outstanding increases by burst.
REQ-008 Every beat with ddr3_emif_rddata_valid high is written into the FIFO the same cycle and decreases outstanding by 1. Acceptance and return in the same cycle update outstanding by (+burst - 1).
REQ-009 When words_left reaches 0, ISSUE goes to DRAIN. DRAIN goes to DONE when outstanding reaches 0. DONE pulses rd_done and returns to IDLE. rd_busy is high in CALC, ISSUE, DRAIN and DONE.
REQ-010 Mask per returned beat:
  - First beat: bits [off-1:0] cleared.
  - Last beat: bits at or above e cleared, where e = (off + rd_byte_cnt) mod BYTES and e != 0.
  - Single-word request: both rules applied (AND).
  - All other beats: all ones.
  - out_last is set on beat total_words.
REQ-011 Output FIFO:
  - Show-ahead; out_data, out_mask and out_last are valid whenever out_valid is high.
  - A word leaves on out_valid & out_ready.
  - Simultaneous write and read keep the occupancy unchanged.
  - out_valid = FIFO not empty, independent of state, so words may still drain after rd_done.
REQ-012 rddata_valid received while outstanding == 0 is dropped and not written to the FIFO.
REQ-013 Address arithmetic wraps modulo 2^ADDR_W.

Reset
REQ-014 While ddr3_emif_rst is high, the block holds these values regardless of clock:
  - State is IDLE.
  - ddr3_emif_read, rd_busy, rd_done, out_valid and out_last are 0.
  - ddr3_emif_addr and ddr3_emif_burst_count are 0.
  - Counters are 0 and the FIFO is empty.
REQ-015 Reset asserted mid-request abandons the request without issuing rd_done. Beats returned after reset are dropped per REQ-012.

Verification
REQ-016 Unaligned multi-word request:
  - Stimulus: addr 0x23, cnt 64.
  - Response: 3 words from word address 1, one command with burst_count 3.
  - Masks: 0xFFFFFFF8, 0xFFFFFFFF, 0x00000007; out_last on the 3rd word.
REQ-017 Single word:
  - Stimulus: addr 0x45, cnt 4.
  - Response: one command at addr 2 with burst 1; mask 0x000001E0 with out_last=1; rd_done once.
REQ-018 Burst split:
  - Stimulus: addr 0, cnt 1280.
  - Response: commands at addresses 0/16/32 with bursts 16/16/8; 40 words delivered in order.
REQ-019 Backpressure:
  - Stimulus: out_ready=0, cnt 200*32, ready toggling randomly.
  - Response: at most 128 beats outstanding plus buffered; no overflow; full data after out_ready=1.
REQ-020 Zero count: rd_done 2 cycles after rd_start; no ddr3_emif_read and no output words.
REQ-021 Reset mid-request:
  - Stimulus: reset during DRAIN with 5 beats outstanding, then 5 stray rddata_valid beats.
  - Response: all outputs 0, FIFO empty, stray beats ignored; the next request behaves correctly.
